// File: rtl/bit_swizzling_pkg.sv
// Shared constants and types for the bit-swizzling demonstrator.
// Holds operand and result widths, the constant tail pattern, the lane count,
// and the per-lane request/response structs used by the top level.
package bit_swizzling_pkg;

  localparam int C_W       = 5;   // operand C width
  localparam int D_W       = 5;   // operand D width
  localparam int Y_W       = 9;   // swizzled result width
  localparam int REP       = 3;   // replication count of D[0]
  localparam int NUM_LANES = 3;   // sv, v, vhd
  localparam int KEY_W     = 4;   // significant input bits per lane: C[2:0], D[0]

  localparam logic [2:0] TAIL = 3'b101;

  // Lane slot order inside the packed lane arrays.
  typedef enum logic [1:0] {
    LANE_SV  = 2'd0,
    LANE_V   = 2'd1,
    LANE_VHD = 2'd2
  } lane_id_e;

  typedef struct packed {
    logic [C_W-1:0] c;
    logic [D_W-1:0] d;
  } lane_req_t;

  typedef struct packed {
    logic [Y_W-1:0] y;
  } lane_rsp_t;

endpackage

// File: rtl/bit_swizzle_lane.sv
// One swizzle lane: purely combinational, zero latency.
//   c : 5-bit operand, only c[2:0] contributes
//   d : 5-bit operand, only d[0] contributes
//   y : 9-bit result {c[2:1], {3{d[0]}}, c[0], 3'b101}
module bit_swizzle_lane
  import bit_swizzling_pkg::*;
(
  input  logic [C_W-1:0] c,
  input  logic [D_W-1:0] d,
  output logic [Y_W-1:0] y
);

  assign y = {c[2:1], {REP{d[0]}}, c[0], TAIL};

  // The upper operand bits are don't-care by definition of the mapping.
  logic unused_ops;
  assign unused_ops = ^{c[C_W-1:3], d[D_W-1:1]};

endmodule

// File: rtl/bit_swizzling_top.sv
// Bit-swizzling demonstrator top level.
// Three independent combinational lanes (sv, v, vhd) map C/D to Y. A registered
// cross-check flags the case where lanes that see the same significant input bits
// produce different results.
//   clk          : rising-edge clock for the two cross-check flops only
//   reset        : synchronous, active-high; clears both flags
//   C_*/D_*      : per-lane 5-bit operands
//   Y_*          : per-lane 9-bit swizzled results (same-cycle)
//   mismatch_q   : lanes with equal inputs disagreed in the previous cycle
//   mismatch_stk : sticky OR of mismatch_q, cleared only by reset
module bit_swizzling_top
  import bit_swizzling_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic [C_W-1:0] C_sv,
  input  logic [D_W-1:0] D_sv,
  output logic [Y_W-1:0] Y_sv,
  input  logic [C_W-1:0] C_v,
  input  logic [D_W-1:0] D_v,
  output logic [Y_W-1:0] Y_v,
  input  logic [C_W-1:0] C_vhd,
  input  logic [D_W-1:0] D_vhd,
  output logic [Y_W-1:0] Y_vhd,
  output logic           mismatch_q,
  output logic           mismatch_stk
);

  lane_req_t [NUM_LANES-1:0]            req;
  lane_rsp_t [NUM_LANES-1:0]            rsp;
  logic      [NUM_LANES-1:0][Y_W-1:0]   y_chk;
  logic      [NUM_LANES-1:0][KEY_W-1:0] key;

  assign req[LANE_SV]  = '{c: C_sv,  d: D_sv};
  assign req[LANE_V]   = '{c: C_v,   d: D_v};
  assign req[LANE_VHD] = '{c: C_vhd, d: D_vhd};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    bit_swizzle_lane u_lane (
      .c (req[i].c),
      .d (req[i].d),
      .y (rsp[i].y)
    );
    assign key[i] = {req[i].c[2:0], req[i].d[0]};
  end

  assign Y_sv  = rsp[LANE_SV].y;
  assign Y_v   = rsp[LANE_V].y;
  assign Y_vhd = rsp[LANE_VHD].y;

  // Compare what actually leaves the block, so anything that disturbs an output
  // port between the lane and the pin is caught as well.
  assign y_chk = {Y_vhd, Y_v, Y_sv};

  logic eq_in, eq_out, mismatch;

  always_comb begin
    eq_in  = 1'b1;
    eq_out = 1'b1;
    for (int i = 1; i < NUM_LANES; i++) begin
      eq_in  = eq_in  & (key[i]   == key[0]);
      eq_out = eq_out & (y_chk[i] == y_chk[0]);
    end
    mismatch = eq_in & ~eq_out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mismatch_q   <= 1'b0;
      mismatch_stk <= 1'b0;
    end else begin
      mismatch_q   <= mismatch;
      mismatch_stk <= mismatch_stk | mismatch;
    end
  end

endmodule

// File: tb/tb_bit_swizzling_top.sv
module tb_bit_swizzling_top;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] C_sv, D_sv, C_v, D_v, C_vhd, D_vhd;
  logic [8:0] Y_sv, Y_v, Y_vhd;
  logic       mismatch_q, mismatch_stk;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bit_swizzling_top dut (
    .clk          (clk),
    .reset        (reset),
    .C_sv         (C_sv),
    .D_sv         (D_sv),
    .Y_sv         (Y_sv),
    .C_v          (C_v),
    .D_v          (D_v),
    .Y_v          (Y_v),
    .C_vhd        (C_vhd),
    .D_vhd        (D_vhd),
    .Y_vhd        (Y_vhd),
    .mismatch_q   (mismatch_q),
    .mismatch_stk (mismatch_stk)
  );

  task automatic chk9(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive_all(input logic [4:0] c, input logic [4:0] d);
    C_sv = c; C_v = c; C_vhd = c;
    D_sv = d; D_v = d; D_vhd = d;
  endtask

  task automatic chk_all(input string tag, input logic [8:0] exp);
    chk9({tag, "_sv"},  Y_sv,  exp);
    chk9({tag, "_v"},   Y_v,   exp);
    chk9({tag, "_vhd"}, Y_vhd, exp);
  endtask

  initial begin
    logic [2:0] c3;
    logic       d0;
    logic [8:0] exp;
    logic [1:0] jc;
    logic [3:0] jd;

    reset = 1'b1;
    drive_all(5'b00000, 5'b00000);
    @(posedge clk); #1;
    @(negedge clk);
    chk1("rst_q",   mismatch_q,   1'b0);
    chk1("rst_stk", mismatch_stk, 1'b0);
    chk_all("zero_in_reset", 9'b000000101);
    reset = 1'b0;

    // Directed vectors, driven just after a rising edge, checked on the falling edge.
    @(posedge clk); #1;
    drive_all(5'b00000, 5'b00000);
    @(negedge clk);
    chk_all("zero", 9'b000000101);

    @(posedge clk); #1;
    drive_all(5'b00101, 5'b00001);
    @(negedge clk);
    chk_all("c05_d01", 9'b101111101);
    chk1("zero_q", mismatch_q, 1'b0);

    @(posedge clk); #1;
    drive_all(5'b11111, 5'b11110);
    @(negedge clk);
    chk_all("c1f_d1e", 9'b110001101);

    @(posedge clk); #1;
    drive_all(5'b11000, 5'b11111);
    @(negedge clk);
    chk_all("c18_d1f", 9'b001110101);

    // Only ignored bits change: result must hold.
    @(posedge clk); #1;
    drive_all(5'b00000, 5'b00001);
    @(negedge clk);
    chk_all("ign_a", 9'b001110101);
    @(posedge clk); #1;
    drive_all(5'b10000, 5'b10101);
    @(negedge clk);
    chk_all("ign_b", 9'b001110101);

    // All 16 significant combinations, each lane with different junk in the ignored bits.
    for (int k = 0; k < 16; k++) begin
      c3 = k[3:1];
      d0 = k[0];
      exp = {c3[2:1], d0, d0, d0, c3[0], 3'b101};
      @(posedge clk); #1;
      jc = 2'($urandom); jd = 4'($urandom);
      C_sv  = {jc, c3};          D_sv  = {jd, d0};
      jc = 2'($urandom); jd = 4'($urandom);
      C_v   = {jc, c3};          D_v   = {jd, d0};
      C_vhd = {~jc, c3};         D_vhd = {~jd, d0};
      @(negedge clk);
      chk_all($sformatf("exh%0d", k), exp);
    end
    @(negedge clk);
    chk1("exh_q",   mismatch_q,   1'b0);
    chk1("exh_stk", mismatch_stk, 1'b0);

    // Lanes fed different inputs never flag.
    @(posedge clk); #1;
    C_sv = 5'b00001; D_sv = 5'b0;
    C_v  = 5'b00010; D_v  = 5'b1;
    C_vhd = 5'b00111; D_vhd = 5'b0;
    @(negedge clk);
    chk9("diff_sv",  Y_sv,  9'b000000101 | 9'b000001000);
    chk9("diff_v",   Y_v,   9'b011111101 & 9'b011110101);
    chk9("diff_vhd", Y_vhd, 9'b110001101);
    @(negedge clk);
    chk1("diff_q", mismatch_q, 1'b0);

    // Forced lane mismatch with equal inputs.
    @(posedge clk); #1;
    drive_all(5'b00101, 5'b00001);
    force dut.Y_v = 9'h000;
    @(negedge clk);
    chk1("force_pre_q", mismatch_q, 1'b0);
    @(negedge clk);
    chk1("force_q",   mismatch_q,   1'b1);
    chk1("force_stk", mismatch_stk, 1'b1);
    #1 release dut.Y_v;
    @(negedge clk);
    chk9("release_v", Y_v,          9'b101111101);
    chk1("clear_q",   mismatch_q,   1'b0);
    chk1("held_stk",  mismatch_stk, 1'b1);

    // Reset clears both, and beats a same-cycle mismatch.
    force dut.Y_vhd = 9'h1FF;
    reset = 1'b1;
    @(negedge clk);
    chk1("rst2_q",   mismatch_q,   1'b0);
    chk1("rst2_stk", mismatch_stk, 1'b0);
    chk9("rst2_sv",  Y_sv,         9'b101111101);
    #1 release dut.Y_vhd;
    reset = 1'b0;
    @(negedge clk);
    chk1("post_q",   mismatch_q,   1'b0);
    chk1("post_stk", mismatch_stk, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
